// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 active-low matrix keypad front end.
// Scans columns, debounces rows, emits one insere pulse per press.
module keypad_scanner #(
    parameter int CLK_DIV        = 1000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int INSERE_CYCLES  = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] row_in,
    output logic [3:0] col_out,
    output logic [3:0] numero,
    output logic       insere,
    output logic       busy
);

    localparam int TW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [TW-1:0] TMAX = TW'(CLK_DIV - 1);
    localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
    localparam logic [7:0] IC = 8'(INSERE_CYCLES);

    localparam logic [1:0] SCAN         = 2'd0;
    localparam logic [1:0] DEBOUNCE     = 2'd1;
    localparam logic [1:0] EMIT         = 2'd2;
    localparam logic [1:0] WAIT_RELEASE = 2'd3;

    logic [3:0]    rs_meta;
    logic [3:0]    rs;
    logic [TW-1:0] tcnt;
    logic          tick;
    logic [1:0]    state;
    logic [1:0]    col_idx;
    logic [1:0]    cap_row;
    logic [3:0]    cap_pat;
    logic [3:0]    dcnt;
    logic [3:0]    rcnt;
    logic [7:0]    pcnt;
    logic          one_low;
    logic [1:0]    row_hit;
    logic [1:0]    key_row;
    logic [3:0]    code;

    // Two-flop synchroniser for the asynchronous row inputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rs_meta <= 4'b1111;
            rs      <= 4'b1111;
        end else begin
            rs_meta <= row_in;
            rs      <= rs_meta;
        end
    end

    // Free-running scan tick divider
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tcnt <= '0;
        end else if (tick) begin
            tcnt <= '0;
        end else begin
            tcnt <= tcnt + 1'b1;
        end
    end

    assign tick    = (tcnt == TMAX);
    assign col_out = ~(4'b0001 << col_idx);

    // Single-row detect; anything else is idle or ghosting
    always_comb begin
        one_low = 1'b0;
        row_hit = 2'd0;
        unique case (1'b1)
            (rs == 4'b1110): begin one_low = 1'b1; row_hit = 2'd0; end
            (rs == 4'b1101): begin one_low = 1'b1; row_hit = 2'd1; end
            (rs == 4'b1011): begin one_low = 1'b1; row_hit = 2'd2; end
            (rs == 4'b0111): begin one_low = 1'b1; row_hit = 2'd3; end
            default: ;
        endcase
    end

    assign key_row = (state == SCAN) ? row_hit : cap_row;

    // Key map; column is frozen once a press is captured
    always_comb begin
        code = 4'd0;
        case ({key_row, col_idx})
            4'h0: code = 4'd1;
            4'h1: code = 4'd2;
            4'h2: code = 4'd3;
            4'h3: code = 4'd10;
            4'h4: code = 4'd4;
            4'h5: code = 4'd5;
            4'h6: code = 4'd6;
            4'h7: code = 4'd11;
            4'h8: code = 4'd7;
            4'h9: code = 4'd8;
            4'hA: code = 4'd9;
            4'hB: code = 4'd12;
            4'hC: code = 4'd14;
            4'hD: code = 4'd0;
            4'hE: code = 4'd15;
            default: code = 4'd13;
        endcase
    end

    // Scan / debounce / emit / release state machine
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state   <= SCAN;
            col_idx <= 2'd0;
            cap_row <= 2'd0;
            cap_pat <= 4'b1111;
            dcnt    <= 4'd0;
            rcnt    <= 4'd0;
            pcnt    <= 8'd0;
            numero  <= 4'd0;
            insere  <= 1'b0;
            busy    <= 1'b0;
        end else begin
            unique case (state)
                SCAN: begin
                    if (tick) begin
                        if (one_low) begin
                            cap_row <= row_hit;
                            cap_pat <= rs;
                            dcnt    <= 4'd1;
                            busy    <= 1'b1;
                            pcnt    <= 8'd0;
                            if (DS == 4'd1) begin
                                numero <= code;
                                state  <= EMIT;
                            end else begin
                                state  <= DEBOUNCE;
                            end
                        end else begin
                            col_idx <= col_idx + 2'd1;
                        end
                    end
                end
                DEBOUNCE: begin
                    if (tick) begin
                        if (rs == cap_pat) begin
                            if (dcnt + 4'd1 == DS) begin
                                dcnt   <= DS;
                                numero <= code;
                                pcnt   <= 8'd0;
                                state  <= EMIT;
                            end else begin
                                dcnt <= dcnt + 4'd1;
                            end
                        end else begin
                            dcnt  <= 4'd0;
                            busy  <= 1'b0;
                            state <= SCAN;
                        end
                    end
                end
                EMIT: begin
                    if (pcnt == 8'd0) begin
                        insere <= 1'b1;
                        pcnt   <= 8'd1;
                    end else if (pcnt >= IC) begin
                        insere <= 1'b0;
                        pcnt   <= 8'd0;
                        rcnt   <= 4'd0;
                        state  <= WAIT_RELEASE;
                    end else begin
                        pcnt <= pcnt + 8'd1;
                    end
                end
                default: begin
                    if (tick) begin
                        if (rs == 4'b1111) begin
                            if (rcnt + 4'd1 == DS) begin
                                rcnt  <= DS;
                                busy  <= 1'b0;
                                state <= SCAN;
                            end else begin
                                rcnt <= rcnt + 4'd1;
                            end
                        end else begin
                            rcnt <= 4'd0;
                        end
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: directed bench for keypad_scanner.
// Models the key matrix from col_out and a pressed-key mask.
module tb_keypad_scanner;

    localparam int CLK_DIV = 4;
    localparam int DSCANS  = 3;
    localparam int ICYC    = 2;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] row_in;
    logic [3:0] col_out;
    logic [3:0] numero;
    logic       insere;
    logic       busy;
    logic [15:0] pressed = '0;

    int n_checks = 0;
    int n_errors = 0;

    int         pulse_cnt = 0;
    int         width = 0;
    int         last_width = 0;
    logic       prev_ins = 1'b0;
    logic [3:0] prev_num = 4'd0;
    logic [3:0] pre_num = 4'd0;
    logic [3:0] rise_num = 4'd0;
    logic [3:0] fall_num = 4'd0;

    always #5 clk = ~clk;

    always_comb begin
        row_in = 4'b1111;
        for (int r = 0; r < 4; r++)
            row_in[r] = ~|(pressed[r*4 +: 4] & ~col_out);
    end

    keypad_scanner #(
        .CLK_DIV(CLK_DIV),
        .DEBOUNCE_SCANS(DSCANS),
        .INSERE_CYCLES(ICYC)
    ) dut (
        .clk(clk),
        .reset(reset),
        .row_in(row_in),
        .col_out(col_out),
        .numero(numero),
        .insere(insere),
        .busy(busy)
    );

    always @(negedge clk) begin
        if (insere && !prev_ins) begin
            pulse_cnt = pulse_cnt + 1;
            pre_num   = prev_num;
            rise_num  = numero;
            width     = 1;
        end else if (insere) begin
            width = width + 1;
        end else if (prev_ins) begin
            last_width = width;
            fall_num   = numero;
        end
        prev_ins = insere;
        prev_num = numero;
    end

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    logic [3:0] exp_col [4] = '{4'b1101, 4'b1011, 4'b0111, 4'b1110};

    initial begin
        int n;
        int p0;
        int drops;
        int changes;
        logic seen;
        logic [3:0] prev;

        // reset state
        step(3);
        check("rst_col", col_out, 4'b1110);
        check("rst_num", numero, 4'd0);
        check("rst_ins", insere, 1'b0);
        check("rst_busy", busy, 1'b0);
        reset = 1'b1;

        // column walk, one step per 4 clocks
        for (int k = 0; k < 4; k++) begin
            prev = col_out;
            n = 0;
            do begin
                step(1);
                n++;
            end while (col_out == prev && n < 20);
            check("walk_period", n, 4);
            check("walk_col", col_out, exp_col[k]);
        end

        // clean press of '5'
        p0 = pulse_cnt;
        pressed[5] = 1'b1;
        n = 0;
        while (!busy && n < 64) begin step(1); n++; end
        check("k5_busy", busy, 1'b1);
        check("k5_col", col_out, 4'b1101);
        check("k5_ins_lo", insere, 1'b0);
        n = 0;
        while ((pulse_cnt == p0 || insere) && n < 64) begin step(1); n++; end
        check("k5_pulses", pulse_cnt - p0, 1);
        check("k5_width", last_width, ICYC);
        check("k5_pre", pre_num, 4'd5);
        check("k5_rise", rise_num, 4'd5);
        check("k5_fall", fall_num, 4'd5);
        check("k5_busy_pulse", busy, 1'b1);
        step(20);
        check("k5_single", pulse_cnt - p0, 1);
        check("k5_frozen", col_out, 4'b1101);
        pressed[5] = 1'b0;
        step(8);
        check("k5_rel_hold", busy, 1'b1);
        n = 0;
        while (busy && n < 16) begin step(1); n++; end
        check("k5_rel_done", busy, 1'b0);
        check("k5_rel_col", col_out, 4'b1101);

        // bounce on '9'
        p0 = pulse_cnt;
        pressed[10] = 1'b1;
        n = 0;
        while (!busy && n < 64) begin step(1); n++; end
        check("k9_busy", busy, 1'b1);
        check("k9_col", col_out, 4'b1011);
        pressed[10] = 1'b0;
        n = 0;
        while (busy && n < 8) begin step(1); n++; end
        check("k9_abort", n, 4);
        step(20);
        check("k9_nopulse", pulse_cnt - p0, 0);
        check("k9_num", numero, 4'd5);

        // '#' held for 40 ticks
        p0 = pulse_cnt;
        pressed[14] = 1'b1;
        n = 0;
        while (!busy && n < 64) begin step(1); n++; end
        check("kh_busy", busy, 1'b1);
        check("kh_col", col_out, 4'b1011);
        drops = 0;
        for (int i = 0; i < 40 * CLK_DIV; i++) begin
            step(1);
            if (!busy) drops++;
        end
        check("kh_busy_hold", drops, 0);
        check("kh_pulses", pulse_cnt - p0, 1);
        check("kh_num", rise_num, 4'd15);
        check("kh_width", last_width, ICYC);
        pressed[14] = 1'b0;
        n = 0;
        while (busy && n < 20) begin step(1); n++; end
        check("kh_rel", busy, 1'b0);

        // ghost: rows 0 and 2 on column 0
        p0 = pulse_cnt;
        pressed[0] = 1'b1;
        pressed[8] = 1'b1;
        changes = 0;
        seen = 1'b0;
        prev = col_out;
        for (int i = 0; i < 40; i++) begin
            step(1);
            if (col_out != prev) changes++;
            prev = col_out;
            seen = seen | busy;
        end
        check("gh_busy", seen, 1'b0);
        check("gh_scan", changes, 10);
        check("gh_nopulse", pulse_cnt - p0, 0);
        check("gh_ins", insere, 1'b0);

        // reset during emission of '3'
        pressed = '0;
        step(4);
        p0 = pulse_cnt;
        pressed[2] = 1'b1;
        n = 0;
        while (pulse_cnt == p0 && n < 80) begin step(1); n++; end
        check("k3_ins", insere, 1'b1);
        check("k3_num", numero, 4'd3);
        reset = 1'b0;
        #1;
        check("k3_rst_ins", insere, 1'b0);
        check("k3_rst_busy", busy, 1'b0);
        check("k3_rst_num", numero, 4'd0);
        check("k3_rst_col", col_out, 4'b1110);
        pressed = '0;
        step(2);
        reset = 1'b1;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
